// File: rtl/stick_dodge_controller.sv
`default_nettype none
// ============================================================================
// Module   : stick_dodge_controller
// Brief    : Player/collision/score logic and frame compositor for the falling
//            stick game. Optional button debounce: STICK_DODGE_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stick_dodge_controller #(
    parameter int SCORE_W         = 10,
    parameter int BLINK_BIT       = 22,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic               system_clk,
    input  logic               rst_n,
    input  logic [63:0]        framebuffer,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_start,
    output logic [63:0]        display_frame,
    output logic [2:0]         player_col,
    output logic [SCORE_W-1:0] score,
    output logic               playing,
    output logic               game_over
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [2:0] c_COL_HOME = 3'd3;

    state_t             r_state;
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [2:0]         r_level_d;
    logic [7:0]         r_prev_bottom;
    logic [63:0]        r_frozen;
    logic [BLINK_BIT:0] r_blink;

    logic [2:0]  w_btn_raw;
    logic [2:0]  w_level;
    logic [2:0]  w_press;
    logic [7:0]  w_bottom;
    logic [63:0] w_player_mask;
    logic [63:0] w_over_frame;
    logic        w_hit;
    logic        w_score_evt;

    // Button lanes: bit 0 = left, bit 1 = right, bit 2 = start
    assign w_btn_raw = {btn_start, btn_right, btn_left};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
`ifdef STICK_DODGE_DEBOUNCE_EN
        localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
        logic [c_DB_W-1:0] r_db_cnt;
        logic              r_db_level;

        always_ff @(posedge system_clk) begin
            if (!rst_n) begin
                r_db_cnt   <= '0;
                r_db_level <= 1'b0;
            end else if (r_sync2[gi] != r_db_level) begin
                if (r_db_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db_level <= r_sync2[gi];
                    r_db_cnt   <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end

        assign w_level[gi] = r_db_level;
`else
        assign w_level[gi] = r_sync2[gi];
`endif
    end

    assign w_press       = w_level & ~r_level_d;
    assign w_bottom      = framebuffer[63:56];
    assign w_hit         = framebuffer[{3'b111, player_col}];
    assign w_score_evt   = (r_prev_bottom != 8'd0) && (w_bottom == 8'd0);
    assign w_player_mask = 64'd1 << {3'b111, player_col};
    assign w_over_frame  = (r_frozen & ~w_player_mask)
                         | (r_blink[BLINK_BIT] ? w_player_mask : 64'd0);

    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_sync1       <= 3'd0;
            r_sync2       <= 3'd0;
            r_level_d     <= 3'd0;
            r_prev_bottom <= 8'd0;
            r_frozen      <= 64'd0;
            r_blink       <= '0;
            player_col    <= c_COL_HOME;
            score         <= '0;
            display_frame <= 64'd0;
            playing       <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            r_sync1       <= w_btn_raw;
            r_sync2       <= r_sync1;
            r_level_d     <= w_level;
            r_prev_bottom <= w_bottom;
            r_blink       <= r_blink + (BLINK_BIT + 1)'(1);
            display_frame <= (r_state == ST_OVER) ? w_over_frame
                                                  : (framebuffer | w_player_mask);

            case (r_state)
                ST_IDLE: begin
                    if (w_press[2]) begin
                        r_state    <= ST_PLAY;
                        score      <= '0;
                        player_col <= c_COL_HOME;
                        playing    <= 1'b1;
                        game_over  <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    // A hit freezes everything, including a move or score in the same cycle
                    if (w_hit) begin
                        r_state   <= ST_OVER;
                        r_frozen  <= framebuffer;
                        playing   <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        if (w_press[0] && !w_press[1] && player_col != 3'd0)
                            player_col <= player_col - 3'd1;
                        else if (w_press[1] && !w_press[0] && player_col != 3'd7)
                            player_col <= player_col + 3'd1;
                        if (w_score_evt && score != '1)
                            score <= score + SCORE_W'(1);
                    end
                end
                ST_OVER: begin
                    if (w_press[2]) begin
                        r_state    <= ST_PLAY;
                        score      <= '0;
                        player_col <= c_COL_HOME;
                        r_blink    <= '0;
                        playing    <= 1'b1;
                        game_over  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    playing   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stick_dodge_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_stick_dodge_controller
// Brief    : Directed + randomized bench against a cycle-level game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stick_dodge_controller;

    localparam int SCORE_W         = 3;
    localparam int BLINK_BIT       = 3;
    localparam int DEBOUNCE_CYCLES = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [63:0]        fb;
    logic               bl, br, bs;
    logic [63:0]        display_frame;
    logic [2:0]         player_col;
    logic [SCORE_W-1:0] score;
    logic               playing, game_over;

    always #5 clk = ~clk;

    stick_dodge_controller #(
        .SCORE_W(SCORE_W),
        .BLINK_BIT(BLINK_BIT),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .system_clk(clk),
        .rst_n(rst_n),
        .framebuffer(fb),
        .btn_left(bl),
        .btn_right(br),
        .btn_start(bs),
        .display_frame(display_frame),
        .player_col(player_col),
        .score(score),
        .playing(playing),
        .game_over(game_over)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Game model: 0 = idle, 1 = play, 2 = over
    int          m_state = 0;
    int          m_col   = 3;
    int          m_score = 0;
    int          m_blink = 0;
    int          cyc     = 0;
    logic [63:0] m_disp  = '0;
    logic [63:0] m_frozen = '0;
    logic [7:0]  m_prev  = '0;
    bit          last_l, last_r, last_s;
    int          q_l[$], q_r[$], q_s[$];

    // A button sampled high after a low sample takes effect two edges later
    function automatic bit take_due(ref int q[$], input int now);
        if (q.size() > 0 && q[0] == now) begin
            void'(q.pop_front());
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit pl, pr, ps, hit, sev, blink_on;
        logic [63:0] mask;
        cyc++;
        if (!rst_n) begin
            m_state = 0; m_col = 3; m_score = 0; m_blink = 0;
            m_disp = '0; m_frozen = '0; m_prev = '0;
            q_l.delete(); q_r.delete(); q_s.delete();
            last_l = 0; last_r = 0; last_s = 0;
            return;
        end
        pl = take_due(q_l, cyc);
        pr = take_due(q_r, cyc);
        ps = take_due(q_s, cyc);
        if (bl && !last_l) q_l.push_back(cyc + 2);
        if (br && !last_r) q_r.push_back(cyc + 2);
        if (bs && !last_s) q_s.push_back(cyc + 2);
        last_l = bl; last_r = br; last_s = bs;

        mask     = 64'd1 << (56 + m_col);
        hit      = fb[56 + m_col];
        sev      = (m_prev != 0) && (fb[63:56] == 0);
        blink_on = ((m_blink >> BLINK_BIT) & 1) != 0;
        m_disp   = (m_state == 2) ? ((m_frozen & ~mask) | (blink_on ? mask : 64'd0))
                                  : (fb | mask);
        m_blink  = (m_blink + 1) % (1 << (BLINK_BIT + 1));
        m_prev   = fb[63:56];

        case (m_state)
            0: if (ps) begin m_state = 1; m_score = 0; m_col = 3; end
            1: begin
                if (hit) begin
                    m_state  = 2;
                    m_frozen = fb;
                end else begin
                    if (pl && !pr && m_col > 0) m_col--;
                    else if (pr && !pl && m_col < 7) m_col++;
                    if (sev && m_score < (1 << SCORE_W) - 1) m_score++;
                end
            end
            default: if (ps) begin m_state = 1; m_score = 0; m_col = 3; m_blink = 0; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("player_col", 64'(player_col), 64'(m_col));
        check_val("score", 64'(score), 64'(m_score));
        check_val("playing", 64'(playing), 64'(m_state == 1));
        check_val("game_over", 64'(game_over), 64'(m_state == 2));
        check_val("display_frame", display_frame, m_disp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // 0 = left, 1 = right, 2 = start, 3 = left+right together
    task automatic press(input int which);
        bl = (which == 0 || which == 3);
        br = (which == 1 || which == 3);
        bs = (which == 2);
        tick();
        bl = 0; br = 0; bs = 0;
        ticks(2);
    endtask

    function automatic logic [63:0] with_bottom(input logic [7:0] row);
        logic [63:0] v;
        v = {$urandom, $urandom};
        v[63:56] = row;
        return v;
    endfunction

    initial begin
        rst_n = 0; fb = '0; bl = 0; br = 0; bs = 0;
        ticks(2);
        check_val("rst_col", 64'(player_col), 64'd3);
        check_val("rst_frame", display_frame, 64'd0);
        rst_n = 1;
        ticks(2);

        press(2);
        ticks(1);
        check_val("start_playing", 64'(playing), 64'd1);
        for (int i = 0; i < 5; i++) press(1);
        check_val("col_sat7", 64'(player_col), 64'd7);
        check_val("frame_bit63", 64'(display_frame[63]), 64'd1);

        for (int i = 0; i < 8; i++) press(0);
        press(3);
        check_val("col_both_btn", 64'(player_col), 64'd0);
        for (int i = 0; i < 3; i++) press(1);

        fb = with_bottom(8'b11110111);
        ticks(3);
        fb = with_bottom(8'h00);
        ticks(3);
        check_val("dodge_score", 64'(score), 64'd1);
        check_val("dodge_no_over", 64'(game_over), 64'd0);

        fb = with_bottom(8'b11111101);
        tick();
        check_val("hit_over", 64'(game_over), 64'd1);
        for (int i = 0; i < 24; i++) begin
            fb = {$urandom, $urandom};
            tick();
        end

        fb = '0;
        press(2);
        ticks(1);
        check_val("restart_score", 64'(score), 64'd0);
        check_val("restart_col", 64'(player_col), 64'd3);

        for (int i = 0; i < 5; i++) begin
            fb = with_bottom(8'h01);
            tick();
            fb = with_bottom(8'h00);
            tick();
        end
        check_val("score5", 64'(score), 64'd5);
        rst_n = 0;
        tick();
        check_val("midrst_playing", 64'(playing), 64'd0);
        check_val("midrst_score", 64'(score), 64'd0);
        rst_n = 1;
        ticks(2);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] row;
            int sel;
            rst_n = ($urandom_range(0, 499) != 0);
            bl = ($urandom_range(0, 5) == 0);
            br = ($urandom_range(0, 5) == 0);
            bs = ($urandom_range(0, 30) == 0);
            sel = $urandom_range(0, 3);
            row = 8'($urandom);
            if (sel < 2) row = 8'h00;
            else if (sel == 2 || $urandom_range(0, 9) != 0) row[m_col] = 1'b0;
            fb = with_bottom(row);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
